instr_mem_loadable: RTL
=======================

Name: instr_mem_loadable

Overview:
Parametrised, loadable instruction memory replacing the fixed combinational instruction ROM of the single-cycle/pipelined MIPS cores. A post-reset clear engine fills the word array with NOPs, a boot loader port writes the program, and a registered fetch port serves the IF stage with 1-cycle latency and stall hold. Out-of-range and misaligned fetches return a configurable trap instruction and raise flags.

Parameters:
DEPTH, 256, number of 32-bit instruction words (power of 2, 4..4096)
AW, 8, word index width, equals log2(DEPTH)
DEFAULT_INSTR, 32'h08001000, word returned for out-of-range or misaligned fetch (jump to exception handler)
NOP_INSTR, 32'h00000000, fill value written by the clear engine

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
load_start  in  1  pulse in RUN: enter LOAD state
load_wr  in  1  write strobe in LOAD
load_addr  in  AW  word index for load write
load_data  in  32  instruction word to write
load_done  in  1  pulse in LOAD: return to RUN
fetch_en  in  1  fetch request from IF stage
stall  in  1  hold current fetch output
fetch_addr  in  32  byte address from PC
instr  out  32  fetched instruction
instr_valid  out  1  instr holds a valid fetch result
fetch_ready  out  1  high only in RUN state
fetch_oob  out  1  registered: last fetch word index >= DEPTH
fetch_misalign  out  1  registered: last fetch had fetch_addr[1:0] != 0
busy  out  1  high in CLEAR or LOAD

Behaviour:
- Single clock; reset is asynchronous and active-low (reset low clears state immediately).
- Reset values: state=CLEAR, clear counter=0, instr=NOP_INSTR, instr_valid=0, fetch_ready=0, fetch_oob=0, fetch_misalign=0, busy=1. Array contents are not reset.
- Word index = fetch_addr[30:2]; bit 31 (kernel bit) ignored. In range iff fetch_addr[30:2] < DEPTH (upper index bits above AW all zero).
- States:
  - CLEAR: writes NOP_INSTR to word[cnt] each cycle; cnt increments 0..DEPTH-1; after writing DEPTH-1 -> RUN. Takes exactly DEPTH cycles. Inputs load_* and fetch_en ignored.
  - RUN: fetch_ready=1, busy=0. load_start=1 -> LOAD next cycle (fetch_en sampled in the same cycle is still served). load_wr ignored.
  - LOAD: busy=1, fetch_ready=0. load_wr=1 writes load_data to word[load_addr] at the clock edge. load_done=1 -> RUN; a load_wr in the same cycle as load_done is still performed. load_start is ignored.
- Fetch (RUN only): when fetch_en=1 and stall=0 at edge N, instr/instr_valid/flags update at edge N; they are visible during cycle N+1 (1-cycle latency).
  - Misaligned: instr=DEFAULT_INSTR, fetch_misalign=1 (takes priority over out-of-range).
  - Out-of-range: instr=DEFAULT_INSTR, fetch_oob=1.
  - Otherwise instr=word[index], both flags 0.
  - instr_valid=1.
- stall=1: instr, instr_valid and flags hold regardless of fetch_en.
- fetch_en=0 with stall=0, or not in RUN: instr_valid=0, instr holds its last value.
- Leaving RUN for LOAD clears instr_valid on the next edge unless stall=1.
- A write in LOAD followed by load_done and then a fetch of the same address returns the new data; there are no read-during-write hazards, since fetch and write never occur in the same state.
- reset asserted mid-CLEAR or mid-LOAD: return immediately to CLEAR with cnt=0; the full clear reruns.

Test Plan:
- Reset released, DEPTH=256: busy=1 for exactly 256 cycles, then fetch_ready=1. Fetch addr 0x0 -> instr=0x00000000, instr_valid=1 one cycle later.
- load_start; write 0x3C114000 to index 3 and 0x08000003 to index 0; load_done. Fetches 0x0C, then 0x00 -> 0x3C114000, then 0x08000003 on consecutive cycles.
- Fetch 0x8000000C (bit 31 set) after the load above -> 0x3C114000. Fetch 0x00000400 (index 256) -> 0x08001000, fetch_oob=1.
- Fetch 0x00000006 -> 0x08001000, fetch_misalign=1, fetch_oob=0. Next fetch of aligned 0x0 clears both flags.
- Fetch index 3, then stall=1 for 3 cycles while fetch_addr changes -> instr remains 0x3C114000 and instr_valid remains 1 throughout.
- reset pulsed low for 1 cycle during LOAD after 2 writes -> busy=1, clear reruns for 256 cycles, then fetch of index 3 returns 0x00000000.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// -----------------------------------------------------------------------------
// instr_mem_loadable
//
// Loadable instruction memory for the MIPS IF stage. After reset a clear
// engine writes NOP_INSTR into every word (exactly DEPTH cycles). The memory
// then serves registered fetches with one cycle of latency. A boot loader can
// move the block into a LOAD state, write words through the load port, and
// return to RUN.
//
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   load_start     pulse in RUN: move to LOAD on the next edge
//   load_wr        write strobe, honoured only in LOAD
//   load_addr      word index for a load write
//   load_data      instruction word for a load write
//   load_done      pulse in LOAD: return to RUN (a same-cycle write still lands)
//   fetch_en       fetch request from the IF stage
//   stall          hold instr / instr_valid / flags unchanged
//   fetch_addr     byte address from the PC (bit 31 = kernel bit, ignored)
//   instr          fetched instruction (registered)
//   instr_valid    instr holds the result of a fetch made on the previous edge
//   fetch_ready    high only while in RUN (registered)
//   fetch_oob      last fetch word index was >= DEPTH (registered)
//   fetch_misalign last fetch byte address was not word aligned (registered)
//   busy           high while in CLEAR or LOAD (registered)
// -----------------------------------------------------------------------------
module instr_mem_loadable #(
    parameter int          DEPTH         = 256,
    parameter int          AW            = 8,
    parameter logic [31:0] DEFAULT_INSTR = 32'h08001000,
    parameter logic [31:0] NOP_INSTR     = 32'h00000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_wr,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          load_done,
    input  logic          fetch_en,
    input  logic          stall,
    input  logic [31:0]   fetch_addr,
    output logic [31:0]   instr,
    output logic          instr_valid,
    output logic          fetch_ready,
    output logic          fetch_oob,
    output logic          fetch_misalign,
    output logic          busy
);

    // Operating modes of the memory.
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          oob_q, oob_d;
    logic          misalign_q, misalign_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    // Word array; deliberately not reset, the clear engine initialises it.
    logic [31:0]   mem_q [DEPTH];

    // Single write port shared by the clear engine and the loader.
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [31:0]   mem_wdata_s;

    // Fetch address decode.
    logic [AW-1:0] fetch_idx_s;
    logic          fetch_in_range_s;
    logic          fetch_misalign_s;
    logic          fetch_fire_s;
    logic [31:0]   mem_rdata_s;

    // The kernel bit plays no part in addressing.
    logic          unused_kernel_bit_s;
    assign unused_kernel_bit_s = fetch_addr[31];

    // Word index is fetch_addr[30:2]; any set bit above the AW-bit index
    // means the word lies beyond the array.
    assign fetch_idx_s      = fetch_addr[AW+1:2];
    assign fetch_in_range_s = ~|fetch_addr[30:AW+2];
    assign fetch_misalign_s = |fetch_addr[1:0];
    assign fetch_fire_s     = (state_q == ST_RUN) && fetch_en && !stall;
    assign mem_rdata_s      = mem_q[fetch_idx_s];

    // Next-state logic for the mode FSM and the clear counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_CLEAR;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_done) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                // Unreachable encoding: recover through a full clear.
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-port arbitration: the clear engine owns the port in CLEAR, the
    // loader in LOAD; nothing is written in RUN, so fetches never see a
    // read-during-write.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = NOP_INSTR;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q;
                mem_wdata_s = NOP_INSTR;
            end
            ST_LOAD: begin
                if (load_wr) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = load_addr;
                    mem_wdata_s = load_data;
                end else begin
                    mem_we_s    = 1'b0;
                    mem_waddr_s = '0;
                    mem_wdata_s = NOP_INSTR;
                end
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_waddr_s = '0;
                mem_wdata_s = NOP_INSTR;
            end
        endcase
    end

    // Fetch result: stall freezes everything, an accepted fetch loads a new
    // result, otherwise only instr_valid drops and the rest holds.
    always_comb begin
        instr_d    = instr_q;
        valid_d    = valid_q;
        oob_d      = oob_q;
        misalign_d = misalign_q;
        if (stall) begin
            instr_d    = instr_q;
            valid_d    = valid_q;
            oob_d      = oob_q;
            misalign_d = misalign_q;
        end else if (fetch_fire_s) begin
            valid_d = 1'b1;
            if (fetch_misalign_s) begin
                // Misalignment wins over out-of-range.
                instr_d    = DEFAULT_INSTR;
                misalign_d = 1'b1;
                oob_d      = 1'b0;
            end else if (!fetch_in_range_s) begin
                instr_d    = DEFAULT_INSTR;
                misalign_d = 1'b0;
                oob_d      = 1'b1;
            end else begin
                instr_d    = mem_rdata_s;
                misalign_d = 1'b0;
                oob_d      = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Status outputs are registered from the next state so they line up with
    // the state register itself.
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (state_d == ST_RUN) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            ready_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    // State, counter and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            oob_q      <= 1'b0;
            misalign_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            oob_q      <= oob_d;
            misalign_q <= misalign_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Word array write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign fetch_ready    = ready_q;
    assign fetch_oob      = oob_q;
    assign fetch_misalign = misalign_q;
    assign busy           = busy_q;

endmodule
